// File: rtl/multi_receiver_block_store.sv
// Multi-channel lighthouse word collector: per-channel holding registers drained round-robin into a shared ring.
// Optional per-channel drop counters are enabled by defining MULTI_RECEIVER_BLOCK_STORE_STATS_EN.
module multi_receiver_block_store #(
    parameter int N_CH      = 4,
    parameter int DATA_W    = 17,
    parameter int TS_W      = 24,
    parameter int DEPTH     = 16,
    parameter int OVERWRITE = 0,
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int IDX_W    = $clog2(DEPTH),
    localparam int BLK_W    = CH_W + TS_W + DATA_W
) (
    input  logic                     clk_96MHz,
    input  logic                     reset_n,
    input  logic [N_CH*DATA_W-1:0]   dec_data,
    input  logic [N_CH*TS_W-1:0]     dec_ts,
    input  logic [N_CH-1:0]          dec_valid,
    output logic [N_CH-1:0]          reset_decoder,
    input  logic                     clear,
    input  logic                     rd_req,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic [BLK_W-1:0]         block_out,
    output logic                     rd_valid,
    output logic                     rd_err,
    output logic [IDX_W:0]           avl_blocks_nb,
    output logic                     full,
    output logic [N_CH-1:0]          overflow,
    output logic [N_CH*8-1:0]        drop_cnt
);

    logic [N_CH-1:0]      r_hold_vld;
    logic [BLK_W-1:0]     r_hold_blk [N_CH];
    logic [BLK_W-1:0]     r_ring [DEPTH];
    logic [IDX_W-1:0]     r_wr_ptr, r_rd_ptr;
    logic [IDX_W:0]       r_count;
    logic [CH_W-1:0]      r_rr;
    logic [N_CH-1:0]      r_rst_dec, r_ovf;
    logic [BLK_W-1:0]     r_blk_out;
    logic                 r_rd_vld, r_rd_err;

    logic                 w_full, w_wr_ok, w_gnt_any, w_rd_in;
    logic [CH_W-1:0]      w_gnt_idx, w_rr_nxt;
    logic [N_CH-1:0]      w_gnt_oh, w_drop;
    logic [IDX_W-1:0]     w_rd_addr;

    assign w_full    = (r_count == (IDX_W+1)'(DEPTH));
    // A full ring without overwrite blocks the grant so held words stay put.
    assign w_wr_ok   = !clear && ((OVERWRITE != 0) || !w_full);
    assign w_rd_in   = ({1'b0, rd_idx} < r_count);
    assign w_rd_addr = r_rd_ptr + rd_idx;
    assign w_rr_nxt  = (int'(w_gnt_idx) == N_CH-1) ? '0 : w_gnt_idx + 1'b1;

    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_gnt_oh  = '0;
        if (w_wr_ok) begin
            for (int k = 0; k < N_CH; k++) begin
                if (!w_gnt_any && r_hold_vld[(int'(r_rr) + k) % N_CH]) begin
                    w_gnt_any = 1'b1;
                    w_gnt_idx = CH_W'((int'(r_rr) + k) % N_CH);
                end
            end
        end
        if (w_gnt_any) w_gnt_oh[w_gnt_idx] = 1'b1;
    end

    assign w_drop = clear ? '0 : (dec_valid & r_hold_vld & ~w_gnt_oh);

    always_ff @(posedge clk_96MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_vld <= '0;
            for (int i = 0; i < N_CH; i++) r_hold_blk[i] <= '0;
        end else if (clear) begin
            r_hold_vld <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (dec_valid[i] && (!r_hold_vld[i] || w_gnt_oh[i])) begin
                    r_hold_vld[i] <= 1'b1;
                    r_hold_blk[i] <= {CH_W'(i), dec_ts[i*TS_W +: TS_W], dec_data[i*DATA_W +: DATA_W]};
                end else if (w_gnt_oh[i]) begin
                    r_hold_vld[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_96MHz) begin
        if (w_gnt_any) r_ring[r_wr_ptr] <= r_hold_blk[w_gnt_idx];
    end

    always_ff @(posedge clk_96MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rr      <= '0;
            r_rst_dec <= '0;
            r_ovf     <= '0;
        end else if (clear) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rr      <= '0;
            r_rst_dec <= '0;
            r_ovf     <= '0;
        end else begin
            r_rst_dec <= w_gnt_oh;
            r_ovf     <= r_ovf | w_drop;
            if (w_gnt_any) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_rr     <= w_rr_nxt;
                if (!w_full) r_count  <= r_count + 1'b1;
                else         r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Read response is sampled against pre-edge pointers, so a same-edge overwrite is not visible.
    always_ff @(posedge clk_96MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_vld  <= 1'b0;
            r_rd_err  <= 1'b0;
            r_blk_out <= '0;
        end else begin
            r_rd_vld <= rd_req && !clear;
            if (rd_req && !clear) begin
                r_rd_err  <= !w_rd_in;
                r_blk_out <= w_rd_in ? r_ring[w_rd_addr] : '0;
            end
        end
    end

`ifdef MULTI_RECEIVER_BLOCK_STORE_STATS_EN
    logic [7:0] r_drop_cnt [N_CH];
    always_ff @(posedge clk_96MHz or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_CH; i++) r_drop_cnt[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < N_CH; i++) r_drop_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++)
                if (w_drop[i] && r_drop_cnt[i] != 8'hFF) r_drop_cnt[i] <= r_drop_cnt[i] + 8'd1;
        end
    end
    for (genvar g = 0; g < N_CH; g++) begin : g_drop
        assign drop_cnt[g*8 +: 8] = r_drop_cnt[g];
    end
`else
    assign drop_cnt = '0;
`endif

    assign reset_decoder = r_rst_dec;
    assign block_out     = r_blk_out;
    assign rd_valid      = r_rd_vld;
    assign rd_err        = r_rd_err;
    assign avl_blocks_nb = r_count;
    assign full          = w_full;
    assign overflow      = r_ovf;

endmodule

// File: tb/tb_multi_receiver_block_store.sv
// Directed bench for multi_receiver_block_store: two instances, drop-newest and overwrite-oldest.
module tb_multi_receiver_block_store;

    localparam int N = 4, DW = 17, TW = 24, D = 16, BW = 2 + TW + DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N*DW-1:0] dd;
    logic [N*TW-1:0] dts;
    logic [N-1:0]  dv;
    logic          clr, rdq;
    logic [3:0]    ridx;

    logic [N-1:0]  rdec0, rdec1, ovf0, ovf1;
    logic [BW-1:0] blk0, blk1;
    logic          rv0, rv1, re0, re1, fl0, fl1;
    logic [4:0]    cnt0, cnt1;
    logic [N*8-1:0] dc0, dc1;

    int n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    multi_receiver_block_store #(.N_CH(N), .DATA_W(DW), .TS_W(TW), .DEPTH(D), .OVERWRITE(0)) u_drop (
        .clk_96MHz(clk), .reset_n(rst_n), .dec_data(dd), .dec_ts(dts), .dec_valid(dv),
        .reset_decoder(rdec0), .clear(clr), .rd_req(rdq), .rd_idx(ridx), .block_out(blk0),
        .rd_valid(rv0), .rd_err(re0), .avl_blocks_nb(cnt0), .full(fl0), .overflow(ovf0), .drop_cnt(dc0));

    multi_receiver_block_store #(.N_CH(N), .DATA_W(DW), .TS_W(TW), .DEPTH(D), .OVERWRITE(1)) u_ovw (
        .clk_96MHz(clk), .reset_n(rst_n), .dec_data(dd), .dec_ts(dts), .dec_valid(dv),
        .reset_decoder(rdec1), .clear(clr), .rd_req(rdq), .rd_idx(ridx), .block_out(blk1),
        .rd_valid(rv1), .rd_err(re1), .avl_blocks_nb(cnt1), .full(fl1), .overflow(ovf1), .drop_cnt(dc1));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_ch(input int c, input logic [DW-1:0] d, input logic [TW-1:0] t);
        dv[c] = 1'b1;
        dd[c*DW +: DW] = d;
        dts[c*TW +: TW] = t;
    endtask

    function automatic logic [63:0] blk(input int c, input logic [TW-1:0] t, input logic [DW-1:0] d);
        logic [1:0] cc;
        cc = 2'(c);
        return 64'({cc, t, d});
    endfunction

    task automatic do_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic rd(input int idx);
        rdq  = 1'b1;
        ridx = 4'(idx);
        tick();
        rdq  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; dd = '0; dts = '0; dv = '0; clr = 1'b0; rdq = 1'b0; ridx = '0;
        tick(2);
        chk("rst_cnt", 64'(cnt0), 0);
        chk("rst_full", 64'(fl0), 0);
        chk("rst_blk", 64'(blk0), 0);
        chk("rst_rv", 64'(rv0), 0);
        rst_n = 1'b1;
        tick();

        // single word on ch2
        set_ch(2, 17'h1ABCD, 24'h123456);
        tick();
        dv = '0;
        chk("single_rdec_early", 64'(rdec0), 0);
        tick();
        chk("single_rdec", 64'(rdec0), 64'h4);
        chk("single_cnt", 64'(cnt0), 1);
        tick();
        chk("single_rdec_off", 64'(rdec0), 0);
        rd(0);
        chk("single_rv", 64'(rv0), 1);
        chk("single_err", 64'(re0), 0);
        chk("single_blk", 64'(blk0), blk(2, 24'h123456, 17'h1ABCD));
        tick();
        chk("single_rv_pulse", 64'(rv0), 0);

        // simultaneous arrivals, round-robin from ch0
        do_clear();
        for (int c = 0; c < N; c++) set_ch(c, 17'(32'h100 + c), 24'(32'h1000 + c));
        tick();
        dv = '0;
        for (int c = 0; c < N; c++) begin
            tick();
            chk("rr_rdec", 64'(rdec0), 64'(1 << c));
        end
        chk("rr_cnt", 64'(cnt0), 4);
        for (int c = 0; c < N; c++) begin
            rd(c);
            chk("rr_blk", 64'(blk0), blk(c, 24'(32'h1000 + c), 17'(32'h100 + c)));
        end
        for (int c = 0; c < N; c++) set_ch(c, 17'(32'h200 + c), 24'(32'h2000 + c));
        tick();
        dv = '0;
        tick();
        chk("rr_wrap_rdec", 64'(rdec0), 64'h1);
        tick(4);
        chk("rr_wrap_cnt", 64'(cnt0), 8);

        // hold overflow on ch1
        do_clear();
        set_ch(0, 17'h0A0, 24'hA0);
        set_ch(1, 17'h0A1, 24'hA1);
        tick();
        dv = '0;
        set_ch(1, 17'h0B1, 24'hB1);
        tick();
        dv = '0;
        tick(3);
        chk("ovf_flag", 64'(ovf0), 64'h2);
        chk("ovf_cnt", 64'(cnt0), 2);
`ifdef MULTI_RECEIVER_BLOCK_STORE_STATS_EN
        chk("ovf_dropcnt", 64'(dc0), 64'h100);
`else
        chk("ovf_dropcnt", 64'(dc0), 0);
`endif
        rd(1);
        chk("ovf_kept", 64'(blk0), blk(1, 24'hA1, 17'h0A1));

        // out-of-range read with count 3
        set_ch(3, 17'h0C3, 24'hC3);
        tick();
        dv = '0;
        tick(3);
        chk("oor_cnt", 64'(cnt0), 3);
        rd(2);
        chk("oor_last_ok", 64'(blk0), blk(3, 24'hC3, 17'h0C3));
        chk("oor_last_err", 64'(re0), 0);
        rd(5);
        chk("oor_rv", 64'(rv0), 1);
        chk("oor_err", 64'(re0), 1);
        chk("oor_blk", 64'(blk0), 0);
        rd(3);
        chk("oor_edge_err", 64'(re0), 1);

        // full policy: 17 words on ch0, one per cycle
        do_clear();
        rd(0);
        chk("empty_err", 64'(re0), 1);
        for (int k = 1; k <= 17; k++) begin
            dv = '0;
            set_ch(0, 17'(k), 24'(k));
            tick();
        end
        dv = '0;
        tick(3);
        chk("full_cnt0", 64'(cnt0), 16);
        chk("full_flag0", 64'(fl0), 1);
        chk("full_cnt1", 64'(cnt1), 16);
        chk("full_flag1", 64'(fl1), 1);
        rd(15);
        chk("full_drop_i15", 64'(blk0), blk(0, 24'd16, 17'd16));
        chk("full_ovw_i15", 64'(blk1), blk(0, 24'd17, 17'd17));
        rd(0);
        chk("full_drop_i0", 64'(blk0), blk(0, 24'd1, 17'd1));
        chk("full_ovw_i0", 64'(blk1), blk(0, 24'd2, 17'd2));
        set_ch(0, 17'd99, 24'd99);
        tick();
        dv = '0;
        chk("full_drop_ovf", 64'(ovf0), 1);
        chk("full_ovw_ovf", 64'(ovf1), 0);
        tick(2);
        rd(15);
        chk("full_ovw_new", 64'(blk1), blk(0, 24'd99, 17'd99));
        chk("full_drop_new", 64'(blk0), blk(0, 24'd16, 17'd16));
        do_clear();
        chk("clr_ovf", 64'(ovf0), 0);
        chk("clr_cnt", 64'(cnt0), 0);
        chk("clr_full", 64'(fl0), 0);
        chk("clr_dropcnt", 64'(dc0), 0);

        // clear in the same cycle as a grant and a read
        set_ch(1, 17'h0D1, 24'hD1);
        tick();
        dv = '0;
        clr = 1'b1; rdq = 1'b1; ridx = '0;
        tick();
        clr = 1'b0; rdq = 1'b0;
        chk("clrg_rv", 64'(rv0), 0);
        chk("clrg_rdec", 64'(rdec0), 0);
        chk("clrg_cnt", 64'(cnt0), 0);
        tick(2);
        chk("clrg_cnt_later", 64'(cnt0), 0);
        chk("clrg_rdec_later", 64'(rdec0), 0);

        // asynchronous reset mid-burst
        for (int c = 0; c < N; c++) set_ch(c, 17'(32'h300 + c), 24'(32'h3000 + c));
        tick();
        dv = '0;
        tick();
        rd(0);
        chk("arst_pre_rv", 64'(rv0), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cnt", 64'(cnt0), 0);
        chk("arst_rv", 64'(rv0), 0);
        chk("arst_rdec", 64'(rdec0), 0);
        chk("arst_blk", 64'(blk0), 0);
        tick();
        rst_n = 1'b1;
        tick(3);
        chk("arst_after_cnt", 64'(cnt0), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
